// File: rtl/bsg_mem_1r1w_sync_mask_write_byte_ctrl.sv
// bsg_mem_1r1w_sync_mask_write_byte_ctrl
//
// Shares one byte-masked 1R1W synchronous memory between num_wr_p write
// requesters and a single read requester. Writes are granted round-robin,
// one per cycle, with a combinational grant. Reads use a valid/ready
// request and a valid/yumi response, backed by a hold register so the
// consumer may stall indefinitely.
//
// A read and a granted write to the same address in the same cycle is a
// collision. By default the read is stalled for that cycle. When the macro
// BSG_MEM_MASK_BYTE_CTRL_BYPASS_EN is defined, the read is accepted anyway,
// and the colliding write bytes are merged into the returned data.
//
// width_p must be a multiple of 8.

module bsg_mem_1r1w_sync_mask_write_byte_ctrl #(
  parameter int width_p       = 32,
  parameter int els_p         = 16,
  parameter int num_wr_p      = 2,
  parameter int addr_width_lp = (els_p > 1) ? $clog2(els_p) : 1,
  parameter int mask_width_lp = width_p / 8
) (
  input  logic                              clk_i,
  input  logic                              reset_i,

  // write requesters
  input  logic [num_wr_p-1:0]               w_v_i,
  input  logic [num_wr_p*mask_width_lp-1:0] w_mask_i,
  input  logic [num_wr_p*addr_width_lp-1:0] w_addr_i,
  input  logic [num_wr_p*width_p-1:0]       w_data_i,
  output logic [num_wr_p-1:0]               w_yumi_o,

  // read requester
  input  logic                              r_v_i,
  input  logic [addr_width_lp-1:0]          r_addr_i,
  output logic                              r_ready_o,
  output logic                              r_v_o,
  output logic [width_p-1:0]                r_data_o,
  input  logic                              r_yumi_i,

  // memory write port
  output logic                              mem_w_v_o,
  output logic [mask_width_lp-1:0]          mem_w_mask_o,
  output logic [addr_width_lp-1:0]          mem_w_addr_o,
  output logic [width_p-1:0]                mem_w_data_o,

  // memory read port
  output logic                              mem_r_v_o,
  output logic [addr_width_lp-1:0]          mem_r_addr_o,
  input  logic [width_p-1:0]                mem_r_data_i
);

  localparam int rr_width_lp = (num_wr_p > 1) ? $clog2(num_wr_p) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PEND = 2'd1,
    HOLD = 2'd2
  } r_state_e;

  // ------------------------------------------------------------------
  // Write arbitration
  // ------------------------------------------------------------------

  logic [rr_width_lp-1:0]    rr_r, rr_n;
  logic [2*num_wr_p-1:0]     w_v_dbl;
  logic [2*num_wr_p-1:0]     grant_dbl;
  logic [num_wr_p-1:0]       w_v_rot;
  logic [num_wr_p-1:0]       grant_rot;
  logic [num_wr_p-1:0]       grant;
  logic [mask_width_lp-1:0]  w_mask_mux;
  logic [addr_width_lp-1:0]  w_addr_mux;
  logic [width_p-1:0]        w_data_mux;

  // Rotate the valids so rr_r lands on bit 0; bit k of the rotated vector
  // is requester (rr_r + k) mod num_wr_p. Doubling the vector makes the
  // wrap-around fall out of a plain shift.
  assign w_v_dbl = {w_v_i, w_v_i};
  assign w_v_rot = num_wr_p'(w_v_dbl >> rr_r);

  // Lowest set bit of the rotated valids wins (first requester at or after rr_r).
  always_comb begin
    // NOTE: every variable assigned here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    grant_rot = '0;
    for (int k = num_wr_p - 1; k >= 0; k--) begin
      if (w_v_rot[k]) begin
        grant_rot    = '0;
        grant_rot[k] = 1'b1;
      end
    end
  end

  // Rotate the one-hot grant back into requester order.
  assign grant_dbl = {{num_wr_p{1'b0}}, grant_rot} << rr_r;
  assign grant     = grant_dbl[num_wr_p-1:0] | grant_dbl[2*num_wr_p-1:num_wr_p];

  // Grants are suppressed during reset; the grant never looks at read inputs.
  assign w_yumi_o  = reset_i ? '0 : grant;
  assign mem_w_v_o = |w_yumi_o;

  // Mux the winner's write fields onto the memory port and advance the pointer.
  always_comb begin
    w_mask_mux = '0;
    w_addr_mux = '0;
    w_data_mux = '0;
    rr_n       = rr_r;
    for (int i = 0; i < num_wr_p; i++) begin
      if (w_yumi_o[i]) begin
        w_mask_mux = w_mask_i[i*mask_width_lp +: mask_width_lp];
        w_addr_mux = w_addr_i[i*addr_width_lp +: addr_width_lp];
        w_data_mux = w_data_i[i*width_p +: width_p];
        rr_n       = (i == num_wr_p - 1) ? '0 : rr_width_lp'(i + 1);
      end
    end
  end

  assign mem_w_mask_o = w_mask_mux;
  assign mem_w_addr_o = w_addr_mux;
  assign mem_w_data_o = w_data_mux;

  // ------------------------------------------------------------------
  // Read path
  // ------------------------------------------------------------------

  r_state_e           state_r, state_n;
  logic               addr_match;
  logic               stall;
  logic               r_accept;
  logic [width_p-1:0] rd_merged;
  logic [width_p-1:0] hold_r;

  // A granted write targets the address being requested this cycle.
  assign addr_match = mem_w_v_o & (r_addr_i == mem_w_addr_o);

`ifdef BSG_MEM_MASK_BYTE_CTRL_BYPASS_EN
  logic                     byp_v_r;
  logic [mask_width_lp-1:0] byp_mask_r;
  logic [width_p-1:0]       byp_data_r;

  // Collisions are absorbed by the bypass registers instead of stalling.
  assign stall = 1'b0;

  // Remember whether the accepted read collided with the concurrent write.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      byp_v_r <= 1'b0;
    end else if (r_accept) begin
      byp_v_r <= addr_match;
    end
  end

  // Capture the colliding write's bytes alongside the accepted read.
  always_ff @(posedge clk_i) begin
    if (r_accept) begin
      byp_mask_r <= mem_w_mask_o;
      byp_data_r <= mem_w_data_o;
    end
  end

  // Overlay the written bytes on the (pre-write) memory data.
  always_comb begin
    rd_merged = mem_r_data_i;
    for (int b = 0; b < mask_width_lp; b++) begin
      if (byp_v_r && byp_mask_r[b]) begin
        rd_merged[b*8 +: 8] = byp_data_r[b*8 +: 8];
      end
    end
  end
`else
  // The read waits one cycle so it observes the completed write.
  assign stall     = r_v_i & addr_match;
  assign rd_merged = mem_r_data_i;
`endif

  assign r_ready_o    = ~reset_i & ~stall & ((state_r == IDLE) | r_yumi_i);
  assign r_accept     = r_v_i & r_ready_o;
  assign mem_r_v_o    = r_accept;
  assign mem_r_addr_o = r_addr_i;

  assign r_v_o    = ~reset_i & (state_r != IDLE);
  assign r_data_o = (state_r == HOLD) ? hold_r : rd_merged;

  // Read FSM next-state: IDLE -> PEND on accept; PEND/HOLD drain on yumi.
  always_comb begin
    state_n = state_r;
    unique case (state_r)
      IDLE: begin
        if (r_accept) state_n = PEND;
      end
      PEND: begin
        if (r_yumi_i) state_n = r_accept ? PEND : IDLE;
        else          state_n = HOLD;
      end
      HOLD: begin
        if (r_yumi_i) state_n = r_accept ? PEND : IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Control state with synchronous reset.
  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of block ordering.
    if (reset_i) begin
      state_r <= IDLE;
      rr_r    <= '0;
    end else begin
      state_r <= state_n;
      rr_r    <= rr_n;
    end
  end

  // Latch the response while it is first presented, for replay under backpressure.
  always_ff @(posedge clk_i) begin
    // NOTE: hold_r is a pure data register qualified by state_r, so it has
    // no reset; its contents are never observed before being written.
    if (state_r == PEND) begin
      hold_r <= rd_merged;
    end
  end

  // Consumer must not take a response that is not being offered.
  assert property (@(posedge clk_i) disable iff (reset_i) !(r_yumi_i && !r_v_o));

endmodule

// File: tb/tb_bsg_mem_1r1w_sync_mask_write_byte_ctrl.sv
// Directed bench for bsg_mem_1r1w_sync_mask_write_byte_ctrl with a byte-masked
// synchronous memory model attached to the memory ports.
// Inputs change just after the falling edge; outputs are sampled 1 ns later.

module tb_bsg_mem_1r1w_sync_mask_write_byte_ctrl;

  localparam int w_lp  = 32;
  localparam int els_lp = 16;
  localparam int n_lp  = 2;
  localparam int aw_lp = 4;
  localparam int mw_lp = 4;

  logic                   clk_i = 1'b0;
  logic                   reset_i;
  logic [n_lp-1:0]        w_v_i;
  logic [n_lp*mw_lp-1:0]  w_mask_i;
  logic [n_lp*aw_lp-1:0]  w_addr_i;
  logic [n_lp*w_lp-1:0]   w_data_i;
  logic [n_lp-1:0]        w_yumi_o;
  logic                   r_v_i;
  logic [aw_lp-1:0]       r_addr_i;
  logic                   r_ready_o;
  logic                   r_v_o;
  logic [w_lp-1:0]        r_data_o;
  logic                   r_yumi_i;
  logic                   mem_w_v_o;
  logic [mw_lp-1:0]       mem_w_mask_o;
  logic [aw_lp-1:0]       mem_w_addr_o;
  logic [w_lp-1:0]        mem_w_data_o;
  logic                   mem_r_v_o;
  logic [aw_lp-1:0]       mem_r_addr_o;
  logic [w_lp-1:0]        mem_r_data_i;

  int total = 0;
  int bad   = 0;

  always #5 clk_i = ~clk_i;

  bsg_mem_1r1w_sync_mask_write_byte_ctrl #(
    .width_p (w_lp),
    .els_p   (els_lp),
    .num_wr_p(n_lp)
  ) dut (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .w_v_i       (w_v_i),
    .w_mask_i    (w_mask_i),
    .w_addr_i    (w_addr_i),
    .w_data_i    (w_data_i),
    .w_yumi_o    (w_yumi_o),
    .r_v_i       (r_v_i),
    .r_addr_i    (r_addr_i),
    .r_ready_o   (r_ready_o),
    .r_v_o       (r_v_o),
    .r_data_o    (r_data_o),
    .r_yumi_i    (r_yumi_i),
    .mem_w_v_o   (mem_w_v_o),
    .mem_w_mask_o(mem_w_mask_o),
    .mem_w_addr_o(mem_w_addr_o),
    .mem_w_data_o(mem_w_data_o),
    .mem_r_v_o   (mem_r_v_o),
    .mem_r_addr_o(mem_r_addr_o),
    .mem_r_data_i(mem_r_data_i)
  );

  // Memory model: read samples the pre-write contents, writes are byte-masked.
  logic [w_lp-1:0] mem [els_lp];

  initial begin
    for (int i = 0; i < els_lp; i++) mem[i] = '0;
    mem_r_data_i = '0;
  end

  always @(posedge clk_i) begin
    if (mem_r_v_o) mem_r_data_i <= mem[mem_r_addr_o];
    if (mem_w_v_o) begin
      for (int b = 0; b < mw_lp; b++) begin
        if (mem_w_mask_o[b]) mem[mem_w_addr_o][b*8 +: 8] <= mem_w_data_o[b*8 +: 8];
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Start a cycle: wait for the falling edge and return inputs to idle.
  task automatic begin_step(input logic rst);
    @(negedge clk_i);
    reset_i  = rst;
    w_v_i    = '0;
    w_mask_i = '0;
    w_addr_i = '0;
    w_data_i = '0;
    r_v_i    = 1'b0;
    r_addr_i = '0;
    r_yumi_i = 1'b0;
  endtask

  task automatic set_wr(input int i, input logic [aw_lp-1:0] a,
                        input logic [w_lp-1:0] d, input logic [mw_lp-1:0] m);
    w_v_i[i]                   = 1'b1;
    w_addr_i[i*aw_lp +: aw_lp] = a;
    w_data_i[i*w_lp +: w_lp]   = d;
    w_mask_i[i*mw_lp +: mw_lp] = m;
  endtask

  task automatic set_rd(input logic [aw_lp-1:0] a, input logic yumi);
    r_v_i    = 1'b1;
    r_addr_i = a;
    r_yumi_i = yumi;
  endtask

  logic [n_lp-1:0] exp_grant [5];

  initial begin
    exp_grant = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01};
    reset_i  = 1'b1;
    w_v_i    = '0;
    w_mask_i = '0;
    w_addr_i = '0;
    w_data_i = '0;
    r_v_i    = 1'b0;
    r_addr_i = '0;
    r_yumi_i = 1'b0;

    // Reset: requests present but every output forced low.
    begin_step(1'b1);
    set_wr(0, 4'd0, 32'h1, 4'h0);
    set_wr(1, 4'd1, 32'h2, 4'h0);
    set_rd(4'd0, 1'b0);
    #1;
    check("rst_w_yumi", w_yumi_o, 2'b00);
    check("rst_mem_w_v", mem_w_v_o, 1'b0);
    check("rst_mem_r_v", mem_r_v_o, 1'b0);
    check("rst_r_v", r_v_o, 1'b0);
    check("rst_r_ready", r_ready_o, 1'b0);
    begin_step(1'b1);

    // Contention with zero masks: 0,1,0,1 then back to 0.
    for (int c = 0; c < 5; c++) begin
      begin_step(1'b0);
      set_wr(0, 4'd0, 32'h1, 4'h0);
      set_wr(1, 4'd1, 32'h2, 4'h0);
      #1;
      check($sformatf("rr_grant_%0d", c), w_yumi_o, exp_grant[c]);
      if (c == 1) begin
        check("zero_mask_w_v", mem_w_v_o, 1'b1);
        check("zero_mask_data", mem_w_data_o, 32'h2);
        check("zero_mask_mask", mem_w_mask_o, 4'h0);
      end
    end

    // Pointer at 1, only requester 0 valid: search wraps to 0.
    begin_step(1'b0);
    set_wr(0, 4'd2, 32'h0, 4'h0);
    #1;
    check("wrap_grant", w_yumi_o, 2'b01);

    // Masked writes to addr 3, plus a full write to addr 5.
    begin_step(1'b0);
    set_wr(0, 4'd3, 32'hAABBCCDD, 4'hF);
    #1;
    check("wr1_grant", w_yumi_o, 2'b01);
    check("wr1_addr", mem_w_addr_o, 4'd3);
    check("wr1_data", mem_w_data_o, 32'hAABBCCDD);
    begin_step(1'b0);
    set_wr(1, 4'd3, 32'h11223344, 4'b0101);
    #1;
    check("wr2_grant", w_yumi_o, 2'b10);
    check("wr2_mask", mem_w_mask_o, 4'b0101);
    begin_step(1'b0);
    set_wr(0, 4'd5, 32'h5555AAAA, 4'hF);
    #1;
    check("wr3_grant", w_yumi_o, 2'b01);

    // Read addr 3.
    begin_step(1'b0);
    set_rd(4'd3, 1'b0);
    #1;
    check("rd3_ready", r_ready_o, 1'b1);
    check("rd3_mem_r_v", mem_r_v_o, 1'b1);
    check("rd3_mem_r_addr", mem_r_addr_o, 4'd3);
    check("rd3_idle_v", r_v_o, 1'b0);

    // Response withheld for three cycles while a read of addr 5 waits.
    for (int h = 0; h < 3; h++) begin
      begin_step(1'b0);
      set_rd(4'd5, 1'b0);
      if (h == 1) set_wr(0, 4'd3, 32'h0, 4'hF);  // overwrite addr 3 under HOLD
      #1;
      check($sformatf("bp_v_%0d", h), r_v_o, 1'b1);
      check($sformatf("bp_data_%0d", h), r_data_o, 32'hAA22CC44);
      check($sformatf("bp_ready_%0d", h), r_ready_o, 1'b0);
      check($sformatf("bp_mem_r_v_%0d", h), mem_r_v_o, 1'b0);
    end

    // Yumi together with the new read of addr 5.
    begin_step(1'b0);
    set_rd(4'd5, 1'b1);
    #1;
    check("bp_yumi_ready", r_ready_o, 1'b1);
    check("bp_yumi_data", r_data_o, 32'hAA22CC44);
    check("bp_yumi_mem_r_v", mem_r_v_o, 1'b1);

    // Addr 5 returned; a write to addr 5 now must not disturb it.
    begin_step(1'b0);
    r_yumi_i = 1'b1;
    set_wr(1, 4'd5, 32'h0, 4'hF);
    #1;
    check("rd5_v", r_v_o, 1'b1);
    check("rd5_data", r_data_o, 32'h5555AAAA);
    check("rd5_wr_grant", w_yumi_o, 2'b10);

    begin_step(1'b0);
    #1;
    check("idle_v", r_v_o, 1'b0);
    check("idle_ready", r_ready_o, 1'b1);

    // Collision at addr 7: write 0xFFFFFFFF, mask 0011, old contents 0.
    begin_step(1'b0);
    set_wr(0, 4'd7, 32'hFFFFFFFF, 4'b0011);
    set_rd(4'd7, 1'b0);
    #1;
    check("col_grant", w_yumi_o, 2'b01);
`ifdef BSG_MEM_MASK_BYTE_CTRL_BYPASS_EN
    check("col_ready", r_ready_o, 1'b1);
    check("col_mem_r_v", mem_r_v_o, 1'b1);
`else
    check("col_ready", r_ready_o, 1'b0);
    check("col_mem_r_v", mem_r_v_o, 1'b0);
    begin_step(1'b0);
    set_rd(4'd7, 1'b0);
    #1;
    check("col_retry_ready", r_ready_o, 1'b1);
`endif
    begin_step(1'b0);
    r_yumi_i = 1'b1;
    #1;
    check("col_v", r_v_o, 1'b1);
    check("col_data", r_data_o, 32'h0000FFFF);
    begin_step(1'b0);
    #1;
    check("col_done_v", r_v_o, 1'b0);

    // Reset while a read is pending; pointer left at 1 beforehand.
    begin_step(1'b0);
    set_rd(4'd3, 1'b0);
    set_wr(0, 4'd9, 32'h9, 4'hF);
    #1;
    check("pre_rst_accept", mem_r_v_o, 1'b1);
    begin_step(1'b1);
    set_wr(0, 4'd0, 32'h1, 4'h0);
    set_wr(1, 4'd1, 32'h2, 4'h0);
    #1;
    check("midrst_r_v", r_v_o, 1'b0);
    check("midrst_w_yumi", w_yumi_o, 2'b00);
    check("midrst_r_ready", r_ready_o, 1'b0);
    begin_step(1'b0);
    #1;
    check("post_rst_r_v", r_v_o, 1'b0);
    check("post_rst_ready", r_ready_o, 1'b1);
    begin_step(1'b0);
    set_wr(0, 4'd0, 32'h1, 4'h0);
    set_wr(1, 4'd1, 32'h2, 4'h0);
    #1;
    check("post_rst_grant", w_yumi_o, 2'b01);

    begin_step(1'b0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bsg_mem_1r1w_sync_mask_write_byte_ctrl.md
# bsg_mem_1r1w_sync_mask_write_byte_ctrl

Controller that shares one byte-masked 1R1W synchronous memory between `num_wr_p` write requesters and one read requester. Writes are arbitrated round-robin, one per cycle. Reads use a valid/ready request and a valid/yumi response, with an output hold register. Same-address read/write collisions are resolved by stalling the read or, optionally, by bypass. The block sits directly in front of the memory and drives every memory port.

## Interface
Parameters:
- `width_p`, none (required), data width; must be a multiple of 8.
- `els_p`, none (required), memory depth.
- `num_wr_p`, 2, number of write requesters (≥1).
- `addr_width_lp`, `BSG_SAFE_CLOG2(els_p)`, address width.
- `mask_width_lp`, width_p/8, byte-mask width.

Ports:
- `clk_i` in 1: the single clock.
- `reset_i` in 1: synchronous, active-high reset.
- `w_v_i` in num_wr_p: per-requester write valid.
- `w_mask_i` in num_wr_p*mask_width_lp: flattened byte masks; requester i uses slice i.
- `w_addr_i` in num_wr_p*addr_width_lp: flattened write addresses.
- `w_data_i` in num_wr_p*width_p: flattened write data.
- `w_yumi_o` out num_wr_p: one-hot grant; the write is consumed this cycle.
- `r_v_i` in 1, `r_addr_i` in addr_width_lp: read request.
- `r_ready_o` out 1: read request accepted when `r_v_i & r_ready_o`.
- `r_v_o` out 1, `r_data_o` out width_p: read response.
- `r_yumi_i` in 1: consumer takes the response.
- `mem_w_v_o`, `mem_w_mask_o`, `mem_w_addr_o`, `mem_w_data_o` out: memory write port.
- `mem_r_v_o`, `mem_r_addr_o` out: memory read port.
- `mem_r_data_i` in width_p: memory read data, valid the cycle after `mem_r_v_o`.

## Operation
Write arbitration:
- Round-robin pointer `rr_r` (0..num_wr_p-1) marks the highest-priority requester.
- The grant goes to the first valid requester at or after `rr_r`, searching with wrap-around.
- On a grant to requester g: `w_yumi_o[g]=1`, `mem_w_v_o=1`, and mask/addr/data are muxed from g.
- After a grant, `rr_r` becomes (g+1) mod num_wr_p. With no grant, `rr_r` holds.
- An all-zero mask is still granted and issued (no byte changes).

Read FSM, states IDLE / PEND / HOLD:
- IDLE: `r_v_o=0`, `r_ready_o=1` unless a collision stall applies. Acceptance drives `mem_r_v_o=1` and `mem_r_addr_o=r_addr_i`, then goes to PEND.
- PEND: `r_v_o=1`, `r_data_o=mem_r_data_i` (pass-through), and the data is captured into `hold_r`.
  - With `r_yumi_i`: go to PEND on a new accept, otherwise IDLE.
  - Without `r_yumi_i`: go to HOLD.
- HOLD: `r_v_o=1`, `r_data_o=hold_r`.
  - `r_yumi_i` with a new accept: go to PEND.
  - `r_yumi_i` alone: go to IDLE.
  - No `r_yumi_i`: stay in HOLD.
- `r_ready_o = (state==IDLE | r_yumi_i) & ~stall`. Back-to-back reads run one per cycle.
- `r_yumi_i` while `r_v_o=0` is illegal (checked by assertion).

Collision: a read accepted in the same cycle as a granted write to the same address.
- Without bypass: `stall = r_v_i & mem_w_v_o & (r_addr_i == mem_w_addr_o)`. The read waits and the write proceeds.
- The stall depends combinationally on `r_v_i`/`r_addr_i`; `w_yumi_o` does not depend on any read input.

## Timing
- Write: request-to-memory latency 0 (combinational grant). Memory is updated at the end of the grant cycle.
- Read: accept in cycle N gives `r_v_o=1` in cycle N+1. Data reflects all writes granted in cycles < N, plus cycle N when bypass is enabled.
- Reset (any cycle, including mid-read):
  - FSM goes to IDLE, `rr_r=0`, `hold_r` is don't-care.
  - Pending read responses are dropped.
  - During reset, all outputs are 0: `w_yumi_o`, `mem_w_v_o`, `mem_r_v_o`, `r_v_o`, `r_ready_o`.
- A write in PEND to the address being read does not affect the returned data, because the read was sampled on the prior edge.

## Configuration
- `BSG_MEM_MASK_BYTE_CTRL_BYPASS_EN` defined: collisions never stall.
  - On a collision accept, the write mask and data are registered (`byp_v_r`, `byp_mask_r`, `byp_data_r`).
  - In PEND, each byte whose mask bit is set comes from `byp_data_r`; the other bytes come from `mem_r_data_i`.
  - The merged value is what `hold_r` captures.
- Undefined: stall behaviour as above, and no bypass registers exist.

## Test plan
- Contention, num_wr_p=2, width_p=32: both `w_v_i` held high for 4 cycles after reset → grants in order 0,1,0,1; `rr_r` returns to 0.
- Masked write: write 0xAABBCCDD at addr 3 with mask 4'b1111, then 0x11223344 with mask 4'b0101, then read addr 3 → `r_data_o=0xAA22CC44` one cycle after accept.
- Backpressure: read addr 3, `r_yumi_i` low for 3 cycles → `r_v_o` stays 1, data stable at 0xAA22CC44, `r_ready_o=0`; yumi with a new read of addr 5 in the same cycle → next cycle returns addr 5 data.
- Collision at addr 7 (old 0x00000000), write 0xFFFFFFFF with mask 4'b0011:
  - Without macro → `r_ready_o=0` that cycle; the read accepted next cycle returns 0x0000FFFF.
  - With macro → accepted immediately, returns 0x0000FFFF.
- Reset in PEND → next cycle `r_v_o=0` and state IDLE; the first write after reset is granted to requester 0 when both requesters are valid.
